// File: rtl/timer_array.sv
// timer_array: an array of N_CH independent down-counting timers on a simple
// word-addressed register bus. Each channel has these registers:
//   0 CTRL   [0] EN, [1] MODE (0 one-shot, 1 auto-reload), [3] IM
//   1 PRESET reload value (CNT_W bits, zero-extended on read)
//   2 COUNT  current count (read-only)
//   3 STATUS [0] PEND (write 1 to clear)
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   Addr     word address; [5:4] channel, [3:2] register
//   WE       write strobe
//   Din      write data
//   Dout     combinational read data
//   IRQ_VEC  registered per-channel interrupt (PEND & IM)
//   IRQ      registered OR of all channel interrupts
module timer_array #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:2]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  output logic [N_CH-1:0] IRQ_VEC,
  output logic            IRQ
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t           state_q  [N_CH];
  state_t           state_d  [N_CH];
  logic [CNT_W-1:0] preset_q [N_CH];
  logic [CNT_W-1:0] preset_d [N_CH];
  logic [CNT_W-1:0] count_q  [N_CH];
  logic [CNT_W-1:0] count_d  [N_CH];
  logic [N_CH-1:0]  en_q, en_d;
  logic [N_CH-1:0]  mode_q, mode_d;
  logic [N_CH-1:0]  im_q, im_d;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  pend_set;
  logic [N_CH-1:0]  irq_vec_q, irq_vec_d;
  logic             irq_q;

  logic [1:0] bus_ch;
  logic [1:0] bus_reg;
  logic       unused_bits;

  assign bus_ch      = Addr[5:4];
  assign bus_reg     = Addr[3:2];
  assign unused_bits = ^{Addr[31:6], Din};

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        state_q[i]  <= S_IDLE;
        preset_q[i] <= '0;
        count_q[i]  <= '0;
      end
      en_q      <= '0;
      mode_q    <= '0;
      im_q      <= '0;
      pend_q    <= '0;
      irq_vec_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      im_q      <= im_d;
      pend_q    <= pend_d;
      irq_vec_q <= irq_vec_d;
      irq_q     <= |irq_vec_d;
    end
  end

  // Per-channel FSM, then bus writes (bus wins on CTRL), then PEND set (set wins on clear)
  always_comb begin
    state_d   = state_q;
    preset_d  = preset_q;
    count_d   = count_q;
    en_d      = en_q;
    mode_d    = mode_q;
    im_d      = im_q;
    pend_d    = pend_q;
    pend_set  = '0;
    irq_vec_d = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      case (state_q[i])
        S_IDLE: begin
          if (en_q[i]) state_d[i] = S_LOAD;
        end
        S_LOAD: begin
          count_d[i] = preset_q[i];
          state_d[i] = S_CNT;
        end
        S_CNT: begin
          if (!en_q[i]) begin
            state_d[i] = S_IDLE;
          end else if (count_q[i] != '0) begin
            count_d[i] = count_q[i] - CNT_W'(1);
          end else begin
            state_d[i]  = S_INT;
            pend_set[i] = 1'b1;
          end
        end
        S_INT: begin
          if (mode_q[i]) begin
            state_d[i] = S_LOAD;
          end else begin
            state_d[i] = S_IDLE;
            en_d[i]    = 1'b0;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase

      if (WE && (bus_ch == 2'(i))) begin
        case (bus_reg)
          REG_CTRL: begin
            en_d[i]   = Din[0];
            mode_d[i] = Din[1];
            im_d[i]   = Din[3];
          end
          REG_PRESET: preset_d[i] = Din[CNT_W-1:0];
          REG_STATUS: if (Din[0]) pend_d[i] = 1'b0;
          default: ;
        endcase
      end

      if (pend_set[i]) pend_d[i] = 1'b1;
      irq_vec_d[i] = pend_d[i] & im_d[i];
    end
  end

  // Read mux; unimplemented channels read as zero
  always_comb begin
    Dout = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (bus_ch == 2'(i)) begin
        case (bus_reg)
          REG_CTRL:   Dout = {28'd0, im_q[i], 1'b0, mode_q[i], en_q[i]};
          REG_PRESET: Dout = 32'(preset_q[i]);
          REG_COUNT:  Dout = 32'(count_q[i]);
          default:    Dout = {31'd0, pend_q[i]};
        endcase
      end
    end
  end

  assign IRQ_VEC = irq_vec_q;
  assign IRQ     = irq_q;

endmodule

// File: tb/tb_timer_array.sv
// Directed testbench for timer_array. Inputs change and outputs are sampled
// just after the falling edge; each bus_write spans exactly one rising edge.
module tb_timer_array;

  localparam int R_CTRL   = 0;
  localparam int R_PRESET = 1;
  localparam int R_COUNT  = 2;
  localparam int R_STATUS = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:2] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout, Dout8;
  logic [1:0]  irq_vec, irq_vec8;
  logic        irq, irq8;
  int          passed = 0;
  int          total = 0;

  always #50 clk = ~clk;

  timer_array #(.N_CH(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .IRQ_VEC(irq_vec), .IRQ(irq)
  );

  timer_array #(.N_CH(2), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout8), .IRQ_VEC(irq_vec8), .IRQ(irq8)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic bus_write(input int ch, input int rg, input logic [31:0] data);
    Addr = {26'd0, 2'(ch), 2'(rg)};
    Din  = data;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
    Din  = '0;
  endtask

  task automatic bus_read(input int ch, input int rg, output logic [31:0] data);
    Addr = {26'd0, 2'(ch), 2'(rg)};
    #1;
    data = Dout;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    #1 reset = 1'b1;
    #1;
    total++; if (irq !== 1'b0) $display("FAIL reset_irq got %0b exp 0", irq); else passed++;
    total++; if (irq_vec !== 2'b00) $display("FAIL reset_irq_vec got %0b exp 0", irq_vec); else passed++;
    bus_read(0, R_CTRL, rd);
    total++; if (rd !== 32'h0) $display("FAIL reset_ctrl got %0h exp 0", rd); else passed++;
    bus_read(1, R_PRESET, rd);
    total++; if (rd !== 32'h0) $display("FAIL reset_preset got %0h exp 0", rd); else passed++;
    @(negedge clk);
    reset = 1'b0;
    tick(3);
    bus_read(0, R_COUNT, rd);
    total++; if (rd !== 32'h0) $display("FAIL reset_idle_count got %0h exp 0", rd); else passed++;
    bus_read(1, R_STATUS, rd);
    total++; if (rd !== 32'h0) $display("FAIL reset_idle_status got %0h exp 0", rd); else passed++;
  endtask

  task automatic test_oneshot;
    logic [31:0] rd;
    bus_write(0, R_PRESET, 32'd5);
    bus_write(0, R_CTRL, 32'h9);
    tick(2);
    bus_read(0, R_COUNT, rd);
    total++; if (rd !== 32'd5) $display("FAIL oneshot_loaded got %0d exp 5", rd); else passed++;
    tick(5);
    bus_read(0, R_STATUS, rd);
    total++; if (rd !== 32'd0) $display("FAIL oneshot_early_pend got %0h exp 0", rd); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL oneshot_early_irq got %0b exp 0", irq); else passed++;
    tick(1);
    bus_read(0, R_STATUS, rd);
    total++; if (rd !== 32'd1) $display("FAIL oneshot_pend got %0h exp 1", rd); else passed++;
    total++; if (irq !== 1'b1) $display("FAIL oneshot_irq got %0b exp 1", irq); else passed++;
    total++; if (irq_vec !== 2'b01) $display("FAIL oneshot_irq_vec got %0b exp 01", irq_vec); else passed++;
    tick(1);
    bus_read(0, R_CTRL, rd);
    total++; if (rd !== 32'h8) $display("FAIL oneshot_ctrl got %0h exp 8", rd); else passed++;
    bus_read(0, R_COUNT, rd);
    total++; if (rd !== 32'h0) $display("FAIL oneshot_count got %0h exp 0", rd); else passed++;
    bus_write(0, R_STATUS, 32'h1);
    total++; if (irq !== 1'b0) $display("FAIL oneshot_clear_irq got %0b exp 0", irq); else passed++;
    bus_read(0, R_STATUS, rd);
    total++; if (rd !== 32'h0) $display("FAIL oneshot_clear_pend got %0h exp 0", rd); else passed++;
  endtask

  task automatic test_autoreload;
    logic [31:0] rd;
    bus_write(1, R_PRESET, 32'd2);
    bus_write(1, R_CTRL, 32'hB);
    tick(4);
    total++; if (irq !== 1'b0) $display("FAIL reload_early_irq got %0b exp 0", irq); else passed++;
    tick(1);
    total++; if (irq !== 1'b1) $display("FAIL reload_first_irq got %0b exp 1", irq); else passed++;
    total++; if (irq_vec !== 2'b10) $display("FAIL reload_irq_vec got %0b exp 10", irq_vec); else passed++;
    bus_write(1, R_STATUS, 32'h1);
    total++; if (irq !== 1'b0) $display("FAIL reload_clear_irq got %0b exp 0", irq); else passed++;
    tick(3);
    total++; if (irq !== 1'b0) $display("FAIL reload_gap_irq got %0b exp 0", irq); else passed++;
    tick(1);
    total++; if (irq !== 1'b1) $display("FAIL reload_second_irq got %0b exp 1", irq); else passed++;
    bus_read(1, R_STATUS, rd);
    total++; if (rd !== 32'h1) $display("FAIL reload_second_pend got %0h exp 1", rd); else passed++;
    bus_write(1, R_CTRL, 32'h0);
    tick(4);
    bus_write(1, R_STATUS, 32'h1);
    bus_read(1, R_STATUS, rd);
    total++; if (rd !== 32'h0) $display("FAIL reload_stopped_pend got %0h exp 0", rd); else passed++;
  endtask

  task automatic test_disable_hold;
    logic [31:0] rd;
    bus_write(0, R_PRESET, 32'd100);
    bus_write(0, R_CTRL, 32'h9);
    tick(61);
    bus_read(0, R_COUNT, rd);
    total++; if (rd !== 32'd41) $display("FAIL hold_count41 got %0d exp 41", rd); else passed++;
    bus_write(0, R_CTRL, 32'h0);
    bus_read(0, R_COUNT, rd);
    total++; if (rd !== 32'd40) $display("FAIL hold_count40 got %0d exp 40", rd); else passed++;
    tick(5);
    bus_read(0, R_COUNT, rd);
    total++; if (rd !== 32'd40) $display("FAIL hold_count_held got %0d exp 40", rd); else passed++;
    bus_read(0, R_STATUS, rd);
    total++; if (rd !== 32'd0) $display("FAIL hold_no_pend got %0h exp 0", rd); else passed++;
    bus_write(0, R_CTRL, 32'h9);
    tick(2);
    bus_read(0, R_COUNT, rd);
    total++; if (rd !== 32'd100) $display("FAIL hold_reload got %0d exp 100", rd); else passed++;
    tick(100);
    bus_read(0, R_STATUS, rd);
    total++; if (rd !== 32'd0) $display("FAIL hold_early_pend got %0h exp 0", rd); else passed++;
    tick(1);
    bus_read(0, R_STATUS, rd);
    total++; if (rd !== 32'd1) $display("FAIL hold_pend103 got %0h exp 1", rd); else passed++;
    tick(1);
    bus_write(0, R_STATUS, 32'h1);
  endtask

  task automatic test_masked;
    logic [31:0] rd;
    bus_write(0, R_PRESET, 32'd0);
    bus_write(0, R_CTRL, 32'h1);
    tick(2);
    bus_read(0, R_STATUS, rd);
    total++; if (rd !== 32'd0) $display("FAIL mask_early_pend got %0h exp 0", rd); else passed++;
    tick(1);
    bus_read(0, R_STATUS, rd);
    total++; if (rd !== 32'd1) $display("FAIL mask_pend got %0h exp 1", rd); else passed++;
    total++; if (irq_vec !== 2'b00) $display("FAIL mask_irq_vec got %0b exp 00", irq_vec); else passed++;
    tick(2);
    total++; if (irq !== 1'b0) $display("FAIL mask_irq got %0b exp 0", irq); else passed++;
    bus_write(0, R_CTRL, 32'h8);
    total++; if (irq !== 1'b1) $display("FAIL mask_unmask_irq got %0b exp 1", irq); else passed++;
    bus_write(0, R_STATUS, 32'h1);
    total++; if (irq !== 1'b0) $display("FAIL mask_clear_irq got %0b exp 0", irq); else passed++;
  endtask

  task automatic test_collisions;
    logic [31:0] rd;
    bus_write(1, R_PRESET, 32'd3);
    bus_write(1, R_CTRL, 32'h1);
    tick(5);
    bus_write(1, R_STATUS, 32'h1);
    bus_read(1, R_STATUS, rd);
    total++; if (rd !== 32'h1) $display("FAIL coll_set_wins got %0h exp 1", rd); else passed++;
    bus_write(1, R_CTRL, 32'h1);
    bus_read(1, R_CTRL, rd);
    total++; if (rd !== 32'h1) $display("FAIL coll_bus_wins got %0h exp 1", rd); else passed++;
    tick(2);
    bus_read(1, R_COUNT, rd);
    total++; if (rd !== 32'd3) $display("FAIL coll_reload got %0d exp 3", rd); else passed++;
    bus_write(1, R_CTRL, 32'h0);
    tick(2);
    bus_write(1, R_STATUS, 32'h1);
    bus_read(1, R_STATUS, rd);
    total++; if (rd !== 32'h0) $display("FAIL coll_final_pend got %0h exp 0", rd); else passed++;
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd;
    bus_write(3, R_CTRL, 32'h9);
    bus_write(3, R_PRESET, 32'h55);
    bus_read(3, R_CTRL, rd);
    total++; if (rd !== 32'h0) $display("FAIL oor_ctrl got %0h exp 0", rd); else passed++;
    bus_read(3, R_PRESET, rd);
    total++; if (rd !== 32'h0) $display("FAIL oor_preset got %0h exp 0", rd); else passed++;
    bus_read(1, R_CTRL, rd);
    total++; if (rd !== 32'h0) $display("FAIL oor_ch1_ctrl got %0h exp 0", rd); else passed++;
    bus_read(1, R_PRESET, rd);
    total++; if (rd !== 32'd3) $display("FAIL oor_ch1_preset got %0h exp 3", rd); else passed++;
    bus_read(0, R_CTRL, rd);
    total++; if (rd !== 32'h8) $display("FAIL oor_ch0_ctrl got %0h exp 8", rd); else passed++;
    tick(5);
    total++; if (irq !== 1'b0) $display("FAIL oor_irq got %0b exp 0", irq); else passed++;
    bus_write(0, R_PRESET, 32'h1FF);
    bus_read(0, R_PRESET, rd);
    total++; if (rd !== 32'h1FF) $display("FAIL preset32_width got %0h exp 1ff", rd); else passed++;
    total++; if (Dout8 !== 32'hFF) $display("FAIL preset8_width got %0h exp ff", Dout8); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    bus_write(0, R_PRESET, 32'd100);
    bus_write(0, R_CTRL, 32'h9);
    bus_write(1, R_PRESET, 32'd0);
    bus_write(1, R_CTRL, 32'h9);
    tick(3);
    total++; if (irq !== 1'b1) $display("FAIL rmid_irq_before got %0b exp 1", irq); else passed++;
    bus_read(0, R_COUNT, rd);
    total++; if (rd !== 32'd97) $display("FAIL rmid_count got %0d exp 97", rd); else passed++;
    reset = 1'b1;
    #1;
    total++; if (irq !== 1'b0) $display("FAIL rmid_irq got %0b exp 0", irq); else passed++;
    total++; if (irq_vec !== 2'b00) $display("FAIL rmid_irq_vec got %0b exp 00", irq_vec); else passed++;
    total++; if (irq8 !== 1'b0) $display("FAIL rmid_irq8 got %0b exp 0", irq8); else passed++;
    total++; if (irq_vec8 !== 2'b00) $display("FAIL rmid_irq_vec8 got %0b exp 00", irq_vec8); else passed++;
    bus_read(0, R_COUNT, rd);
    total++; if (rd !== 32'h0) $display("FAIL rmid_count0 got %0h exp 0", rd); else passed++;
    bus_read(0, R_CTRL, rd);
    total++; if (rd !== 32'h0) $display("FAIL rmid_ctrl0 got %0h exp 0", rd); else passed++;
    bus_read(1, R_STATUS, rd);
    total++; if (rd !== 32'h0) $display("FAIL rmid_status1 got %0h exp 0", rd); else passed++;
    @(negedge clk);
    reset = 1'b0;
    tick(110);
    bus_read(0, R_STATUS, rd);
    total++; if (rd !== 32'h0) $display("FAIL rmid_after_pend got %0h exp 0", rd); else passed++;
    bus_read(0, R_COUNT, rd);
    total++; if (rd !== 32'h0) $display("FAIL rmid_after_count got %0h exp 0", rd); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL rmid_after_irq got %0b exp 0", irq); else passed++;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_disable_hold();
    test_masked();
    test_collisions();
    test_out_of_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got running exp finished");
    $fatal(1);
  end

endmodule
